// File: rtl/uart_pkg.sv
// Shared UART definitions: global data width, receive-controller defaults,
// FSM state encoding and small helpers used across the UART blocks.
// No ports; imported by the UART RTL and its benches.
`timescale 1ns/1ps
`ifndef NUM_DATA_BITS
`define NUM_DATA_BITS 8
`endif

package uart_pkg;

   // Global frame width, shared with the rest of the UART.
   localparam int UART_DATA_BITS     = `NUM_DATA_BITS;

   // Receive-controller defaults.
   localparam int RX_FIFO_DEPTH_DEF  = 8;
   localparam int RX_HOLD_CYCLES_DEF = 32;
   localparam int ERR_COUNT_W        = 8;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_ARM      = 2'd1,
      ST_CAPTURE  = 2'd2,
      ST_RECOVER  = 2'd3
   } rx_state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [ERR_COUNT_W-1:0] sat_inc(input logic [ERR_COUNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-two depth, combinational head read.
// Latency: pushed entry is visible at rd_data the cycle after the push; pop takes effect at the clock edge.
// Backpressure: push while full is accepted only with a same-cycle pop, otherwise dropped; pop while empty is ignored.
// Ports: clk/rst_n, wr_en/wr_data (push), rd_en/rd_data (pop/head), empty, full, count (0..DEPTH).
`timescale 1ns/1ps
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == FULL_CNT);
   assign count   = cnt;
   assign rd_data = mem[rd_ptr];

   // A full FIFO can still take a write when the head leaves in the same cycle.
   assign do_pop  = rd_en && !empty;
   assign do_push = wr_en && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: syncs receiver done/error, captures bytes into a FIFO, resets the receiver between frames.
// Latency: done edge to FIFO push is 4 clk (2-flop sync, edge detect, CAPTURE); rx_enable then low for HOLD_CYCLES.
// Backpressure: none toward the receiver; a byte arriving to a full FIFO without a same-cycle pop is dropped and flagged.
// Ports: en/clr_status (software), rx_done/rx_error/rx_data (receiver in), rx_enable (receiver out),
//        rd_en/rd_data/empty/full/count (consumer), overflow/err_count (status).
`timescale 1ns/1ps
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH  = RX_FIFO_DEPTH_DEF,
   parameter int HOLD_CYCLES = RX_HOLD_CYCLES_DEF,
   parameter int DATA_BITS   = `NUM_DATA_BITS
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic                          clr_status,
   input  logic                          rx_done,
   input  logic                          rx_error,
   input  logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_enable,
   input  logic                          rd_en,
   output logic [DATA_BITS-1:0]          rd_data,
   output logic                          empty,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          overflow,
   output logic [ERR_COUNT_W-1:0]        err_count
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);

   rx_state_t         state_q, state_nxt;
   logic [HW-1:0]     hold_q;
   logic [2:0]        done_sync;
   logic [2:0]        err_sync;
   logic              done_edge;
   logic              err_edge;
   logic              push_req;
   logic              err_inc;
   logic              hold_load;
   logic              ovf_set;

   // Stages [0],[1] are the synchronizer; [2] is the previous value for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_sync <= '0;
         err_sync  <= '0;
      end else begin
         done_sync <= {done_sync[1:0], rx_done};
         err_sync  <= {err_sync[1:0],  rx_error};
      end
   end

   assign done_edge = done_sync[1] && !done_sync[2];
   assign err_edge  = err_sync[1]  && !err_sync[2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_DISABLED;
      else        state_q <= state_nxt;
   end

   // rx_enable stays high through CAPTURE so the receiver-off window is exactly the RECOVER hold.
   always_comb begin
      state_nxt = state_q;
      rx_enable = 1'b0;
      push_req  = 1'b0;
      err_inc   = 1'b0;
      hold_load = 1'b0;
      case (state_q)
         ST_DISABLED: begin
            if (en) state_nxt = ST_ARM;
         end
         ST_ARM: begin
            rx_enable = 1'b1;
            if (err_edge) begin
               // Error beats a coincident done: the byte is not trusted.
               err_inc   = 1'b1;
               hold_load = 1'b1;
               state_nxt = ST_RECOVER;
            end else if (done_edge) begin
               state_nxt = ST_CAPTURE;
            end else if (!en) begin
               state_nxt = ST_DISABLED;
            end
         end
         ST_CAPTURE: begin
            rx_enable = 1'b1;
            push_req  = 1'b1;
            hold_load = 1'b1;
            state_nxt = ST_RECOVER;
         end
         ST_RECOVER: begin
            if (hold_q == '0) state_nxt = en ? ST_ARM : ST_DISABLED;
         end
         default: state_nxt = ST_DISABLED;
      endcase
   end

   // Loaded with HOLD_CYCLES-1 so RECOVER lasts HOLD_CYCLES cycles including the terminal zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
      end else if (hold_load) begin
         hold_q <= HW'(HOLD_CYCLES - 1);
      end else if (state_q == ST_RECOVER && hold_q != '0) begin
         hold_q <= hold_q - 1'b1;
      end
   end

   assign ovf_set = push_req && full && !rd_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         err_count <= '0;
      end else if (clr_status) begin
         overflow  <= 1'b0;
         err_count <= '0;
      end else begin
         if (ovf_set) overflow  <= 1'b1;
         if (err_inc) err_count <= sat_inc(err_count);
      end
   end

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (push_req),
      .wr_data (rx_data),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .empty   (empty),
      .full    (full),
      .count   (count)
   );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl against a queue-based model of the receive path.
// Latency: n/a (bench). Backpressure: n/a.
// Drives a behavioural receiver (sticky done/error, cleared when rx_enable drops) and a random consumer.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
   import uart_pkg::*;

   localparam int DEPTH = 8;
   localparam int HOLD  = 32;
   localparam int DW    = UART_DATA_BITS;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     en;
   logic                     clr_status;
   logic                     rx_done;
   logic                     rx_error;
   logic [DW-1:0]            rx_data;
   logic                     rx_enable;
   logic                     rd_en;
   logic [DW-1:0]            rd_data;
   logic                     empty;
   logic                     full;
   logic [$clog2(DEPTH):0]   count;
   logic                     overflow;
   logic [7:0]               err_count;

   always #5 clk = ~clk;

   uart_rx_ctrl #(
      .FIFO_DEPTH  (DEPTH),
      .HOLD_CYCLES (HOLD),
      .DATA_BITS   (DW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .clr_status (clr_status),
      .rx_done    (rx_done),
      .rx_error   (rx_error),
      .rx_data    (rx_data),
      .rx_enable  (rx_enable),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .empty      (empty),
      .full       (full),
      .count      (count),
      .overflow   (overflow),
      .err_count  (err_count)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: bytes held by the FIFO, error tally, sticky drop flag.
   logic [DW-1:0] exp_q[$];
   int            exp_err = 0;
   bit            exp_ovf = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_count"},    32'(count),     32'(exp_q.size()));
      chk({tag, "_empty"},    32'(empty),     32'(exp_q.size() == 0));
      chk({tag, "_full"},     32'(full),      32'(exp_q.size() == DEPTH));
      chk({tag, "_overflow"}, 32'(overflow),  32'(exp_ovf));
      chk({tag, "_errcnt"},   32'(err_count), 32'(exp_err));
      if (exp_q.size() > 0) chk({tag, "_head"}, 32'(rd_data), 32'(exp_q[0]));
   endtask

   // Counts the remaining low samples of the receiver-off window (first already seen).
   task automatic measure_hold(input string tag);
      int low = 1;
      step();
      while (!rx_enable && low < HOLD + 10) begin
         low++;
         step();
      end
      chk({tag, "_hold"}, 32'(low), 32'(HOLD));
   endtask

   // One receiver frame ending in done and/or error; the receiver clears once disabled.
   task automatic frame(input bit d, input bit e, input logic [DW-1:0] val, input string tag);
      int w = 0;
      rx_data  = val;
      rx_done  = d;
      rx_error = e;
      while (rx_enable && w < 10) begin
         step();
         w++;
      end
      chk({tag, "_drop"}, 32'(rx_enable), 32'd0);
      rx_done  = 1'b0;
      rx_error = 1'b0;
      measure_hold(tag);
      if (e) begin
         exp_err = (exp_err == 255) ? 255 : exp_err + 1;
      end else if (d) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(val);
         else                      exp_ovf = 1'b1;
      end
   endtask

   task automatic pop();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
   endtask

   task automatic drain(input string tag);
      while (exp_q.size() > 0) begin
         chk({tag, "_data"}, 32'(rd_data), 32'(exp_q[0]));
         pop();
      end
      check_status(tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; en = 1'b0; clr_status = 1'b0; rx_done = 1'b0;
      rx_error = 1'b0; rx_data = '0; rd_en = 1'b0;
      repeat (3) step();
      chk("rst_rx_enable", 32'(rx_enable), 32'd0);
      check_status("rst");

      // Out of reset with en low the receiver stays off; en brings ARM in one cycle.
      rst_n = 1'b1;
      step();
      chk("dis_rx_enable", 32'(rx_enable), 32'd0);
      en = 1'b1;
      step();
      chk("arm_rx_enable", 32'(rx_enable), 32'd1);

      frame(1'b1, 1'b0, 8'hA5, "a5");
      check_status("a5");
      chk("a5_value", 32'(rd_data), 32'h0A5);
      chk("a5_rearm", 32'(rx_enable), 32'd1);

      frame(1'b0, 1'b1, 8'h11, "err1");
      check_status("err1");
      drain("drain0");

      // Fill past depth with no reads.
      for (int i = 0; i < 9; i++) begin
         frame(1'b1, 1'b0, DW'(i), "fill9");
         if (i == 7) chk("full_after8", 32'(full), 32'd1);
         if (i == 8) chk("ovf_after9", 32'(overflow), 32'd1);
      end
      check_status("fill9");
      for (int i = 0; i < 8; i++) begin
         chk("seq_data", 32'(rd_data), 32'(i));
         pop();
      end
      check_status("seq_end");

      // Coincident done and error: counted as error, nothing stored.
      frame(1'b1, 1'b1, 8'h3C, "both");
      check_status("both");

      for (int i = 0; i < 300; i++) frame(1'b0, 1'b1, DW'($urandom), "errsat");
      check_status("errsat");
      chk("errsat_val", 32'(err_count), 32'd255);

      clr_status = 1'b1;
      step();
      clr_status = 1'b0;
      exp_err = 0;
      exp_ovf = 1'b0;
      check_status("clr");

      // Full FIFO, capture coinciding with a pop: both happen, count stays at depth.
      for (int i = 0; i < DEPTH; i++) frame(1'b1, 1'b0, DW'($urandom), "fill8");
      check_status("fill8");
      rx_data = 8'h55;
      rx_done = 1'b1;
      repeat (3) step();
      chk("cap_head", 32'(rd_data), 32'(exp_q[0]));
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("cap_drop", 32'(rx_enable), 32'd0);
      rx_done = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back(8'h55);
      measure_hold("cap");
      check_status("cap");
      drain("cap_drain");

      // en dropped while armed returns to DISABLED.
      en = 1'b0;
      step();
      chk("en_off", 32'(rx_enable), 32'd0);
      en = 1'b1;
      step();
      chk("en_on", 32'(rx_enable), 32'd1);

      for (int i = 0; i < 80; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 5)      frame(1'b1, 1'b0, DW'($urandom), "rnd_byte");
         else if (r < 7) frame(1'b0, 1'b1, DW'($urandom), "rnd_err");
         else            pop();
         check_status("rnd");
      end

      // Reset during RECOVER with three bytes queued.
      drain("pre_rst");
      for (int i = 0; i < 3; i++) frame(1'b1, 1'b0, DW'(8'h80 + i), "pre3");
      check_status("pre3");
      rx_data = 8'hEE;
      rx_done = 1'b1;
      for (int w = 0; w < 10 && rx_enable; w++) step();
      chk("mid_recover", 32'(rx_enable), 32'd0);
      rx_done = 1'b0;
      repeat (5) step();
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      exp_err = 0;
      exp_ovf = 1'b0;
      chk("arst_rx_enable", 32'(rx_enable), 32'd0);
      check_status("arst");
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("post_rst_arm", 32'(rx_enable), 32'd1);
      frame(1'b1, 1'b0, 8'h5A, "post_rst");
      check_status("post_rst");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
